mel_band_seq: RTL and testbench
===============================

MEL_BAND_SEQ -- requirements
Module: mel_band_seq

Interface
REQ-001 Parameter NBANDS, default 20, number of mel bands per frame (1..64).
REQ-002 Parameter BINW, default 8, FFT-bin index width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins one frame pass.
REQ-006 cfg_sel  input  1  accumulator source select, captured at start (0 = spectrum path, 1 = power-coefficient path).
REQ-007 tbl_addr  output  6  filter-table band index.
REQ-008 tbl_lo, tbl_hi  input  BINW each  first and last bin of the band; valid 1 cycle after tbl_addr.
REQ-009 bin_addr  output  BINW  spectrum/coefficient register read address; data reaches the accumulator 1 cycle later.
REQ-010 acc_en, acc_new1, acc_sel  output  1 each  accumulator controls (en, new1, sel).
REQ-011 acc_out  input  46  accumulator register value.
REQ-012 mel_data  output  46  completed band sum.
REQ-013 mel_idx  output  6  band index of mel_data.
REQ-014 mel_valid  output  1 / mel_ready  input  1  downstream handshake.
REQ-015 busy  output  1 / done  output  1  pass in progress / one-cycle end-of-frame pulse.

Function
REQ-016 FSM states: IDLE, TBL, TBLW, ACC, DRAIN, OUT, FIN.
REQ-017 IDLE -> TBL on start; band counter := 0; cfg_sel latched into acc_sel.
REQ-018 TBL drives tbl_addr = band counter; TBLW latches tbl_lo/tbl_hi into internal lo/hi registers.
REQ-019 TBLW -> ACC when hi >= lo; otherwise empty band: -> OUT with mel_data = 0 and no acc_en.
REQ-020 ACC issues bin_addr = lo, lo+1, ..., hi, one per cycle (hi-lo+1 cycles).
REQ-021 acc_en is bin-issue delayed 1 cycle; acc_new1 is high with acc_en only for the bin at lo.
REQ-022 After the cycle issuing hi -> DRAIN, held exactly 2 cycles: last acc_en, then accumulator register settle.
REQ-023 Leaving DRAIN: mel_data := acc_out, mel_idx := band counter, mel_valid := 1; state OUT.
REQ-024 OUT holds mel_data/mel_idx/mel_valid stable until mel_valid && mel_ready; no acc_en while in OUT.
REQ-025 On handshake: if band counter = NBANDS-1 -> FIN, else band counter + 1 -> TBL.
REQ-026 FIN asserts done for 1 cycle -> IDLE.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 start while busy is ignored.
REQ-029 hi = 2^BINW-1 must not wrap the bin counter; issue stops at hi.
REQ-030 Band latency = 2 (table) + (hi-lo+1) + 2 (drain) cycles to mel_valid.

Reset
REQ-031 reset forces IDLE at next edge from any state, including mid-ACC or OUT.
REQ-032 Reset values: all outputs 0; internal counters, lo/hi and latched sel 0.

Structure
REQ-033 Shared package mel_pkg holds the state enum, ACCW = 46, band-index width 6, and NBANDS default.
REQ-034 Single module; optional sub-module mel_bin_cnt (loadable up-counter with terminal flag).

Verification
REQ-035 NBANDS=2, bands (3..5),(6..6), spectrum 1,2,3 / 7 -> mel_data 6 idx 0, then 7 idx 1; done once.
REQ-036 Band lo=10 hi=9 -> mel_data 0 with no acc_en pulse; next band proceeds normally.
REQ-037 mel_ready low 5 cycles in OUT -> mel_data/mel_idx stable, bin_addr and acc_en idle, no lost band.
REQ-038 cfg_sel=1 at start -> acc_sel=1 all frame; start pulse mid-frame -> no effect.
REQ-039 reset asserted during ACC of band 1 -> next cycle IDLE, all outputs 0; fresh start gives correct sums.
REQ-040 Band lo=250 hi=255 (BINW=8) -> exactly 6 bin addresses, 6 acc_en cycles, no wrap to 0.

Source files
------------

// File: rtl/mel_pkg.sv
// Shared definitions for the mel band sequencer.
// Holds the FSM state encoding, the accumulator width, the band-index
// width and the default number of bands per frame.
package mel_pkg;

    localparam int ACCW       = 46;
    localparam int IDXW       = 6;
    localparam int NBANDS_DEF = 20;

    typedef enum logic [2:0] {
        IDLE,
        TBL,
        TBLW,
        ACC,
        DRAIN,
        OUT,
        FIN
    } state_t;

endpackage

// File: rtl/mel_band_seq_if.sv
// Downstream band-result stream of the mel band sequencer.
// Ports (master = sequencer side):
//   mel_data  : completed band sum
//   mel_idx   : band index of mel_data
//   mel_valid : result is held and waiting
//   mel_ready : consumer accepts the result
interface mel_band_seq_if;
    import mel_pkg::*;

    logic [ACCW-1:0] mel_data;
    logic [IDXW-1:0] mel_idx;
    logic            mel_valid;
    logic            mel_ready;

    modport master (output mel_data, output mel_idx, output mel_valid, input mel_ready);
    modport slave  (input mel_data, input mel_idx, input mel_valid, output mel_ready);

endinterface

// File: rtl/mel_bin_cnt.sv
// Loadable up-counter used as the FFT-bin issue address.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : force count to zero (highest priority)
//   load       : load load_val
//   inc        : advance by one
//   hi         : terminal value
//   cnt        : current count
//   last       : cnt equals hi
module mel_bin_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] hi,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count; the sequencer never increments past hi, so the counter
    // cannot wrap even when hi is the all-ones bin.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == hi);

endmodule

// File: rtl/mel_band_seq.sv
// Mel filter-bank band sequencer. For each band of a frame it reads the
// band's first/last FFT bin from a filter table, streams the bin addresses
// to an external accumulator, waits for the accumulator to settle and
// hands the sum downstream over a valid/ready stream.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start, cfg_sel      : frame start pulse and accumulator source select
//   tbl_addr            : filter-table band index
//   tbl_lo, tbl_hi      : band bin range, valid one cycle after tbl_addr
//   bin_addr            : spectrum/coefficient read address
//   acc_en/new1/sel     : accumulator controls
//   acc_out             : accumulator value
//   mel                 : result stream (data, index, valid/ready)
//   busy, done          : pass in progress / end-of-frame pulse
module mel_band_seq
    import mel_pkg::*;
#(
    parameter int NBANDS = NBANDS_DEF,
    parameter int BINW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_sel,
    output logic [IDXW-1:0]   tbl_addr,
    input  logic [BINW-1:0]   tbl_lo,
    input  logic [BINW-1:0]   tbl_hi,
    output logic [BINW-1:0]   bin_addr,
    output logic              acc_en,
    output logic              acc_new1,
    output logic              acc_sel,
    input  logic [ACCW-1:0]   acc_out,
    mel_band_seq_if.master    mel,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   band_q, band_d;
    logic [IDXW-1:0]   tbl_addr_q, tbl_addr_d;
    logic [BINW-1:0]   lo_q, lo_d;
    logic [BINW-1:0]   hi_q, hi_d;
    logic              drain_q, drain_d;
    logic              acc_en_q, acc_en_d;
    logic              acc_new1_q, acc_new1_d;
    logic              acc_sel_q, acc_sel_d;
    logic [ACCW-1:0]   mel_data_q, mel_data_d;
    logic [IDXW-1:0]   mel_idx_q, mel_idx_d;
    logic              mel_valid_q, mel_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_clear;
    logic              cnt_load;
    logic              cnt_inc;
    logic              cnt_last;

    mel_bin_cnt #(.W(BINW)) u_bin_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (tbl_lo),
        .inc      (cnt_inc),
        .hi       (hi_q),
        .cnt      (bin_addr),
        .last     (cnt_last)
    );

    // Next-state and next-output logic. acc_en/acc_new1 are computed from
    // the issuing state and registered, so they trail the bin address by
    // one cycle, matching the accumulator's read latency. DRAIN lasts two
    // cycles: the last acc_en, then the accumulator register update.
    always_comb begin
        state_d     = state_q;
        band_d      = band_q;
        tbl_addr_d  = tbl_addr_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        drain_d     = drain_q;
        acc_en_d    = 1'b0;
        acc_new1_d  = 1'b0;
        acc_sel_d   = acc_sel_q;
        mel_data_d  = mel_data_q;
        mel_idx_d   = mel_idx_q;
        mel_valid_d = mel_valid_q;
        done_d      = 1'b0;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = TBL;
                    band_d     = '0;
                    tbl_addr_d = '0;
                    acc_sel_d  = cfg_sel;
                end
            end
            TBL: begin
                state_d = TBLW;
            end
            TBLW: begin
                lo_d = tbl_lo;
                hi_d = tbl_hi;
                if (tbl_hi >= tbl_lo) begin
                    state_d  = ACC;
                    cnt_load = 1'b1;
                end else begin
                    state_d     = OUT;
                    mel_data_d  = '0;
                    mel_idx_d   = band_q;
                    mel_valid_d = 1'b1;
                end
            end
            ACC: begin
                acc_en_d   = 1'b1;
                acc_new1_d = (bin_addr == lo_q);
                if (cnt_last) begin
                    state_d   = DRAIN;
                    drain_d   = 1'b0;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d     = 1'b0;
                    state_d     = OUT;
                    mel_data_d  = acc_out;
                    mel_idx_d   = band_q;
                    mel_valid_d = 1'b1;
                end
            end
            OUT: begin
                if (mel_valid_q && mel.mel_ready) begin
                    mel_valid_d = 1'b0;
                    if (band_q == IDXW'(NBANDS - 1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        band_d     = band_q + IDXW'(1);
                        tbl_addr_d = band_q + IDXW'(1);
                        state_d    = TBL;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            band_q      <= '0;
            tbl_addr_q  <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            drain_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_new1_q  <= 1'b0;
            acc_sel_q   <= 1'b0;
            mel_data_q  <= '0;
            mel_idx_q   <= '0;
            mel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            band_q      <= band_d;
            tbl_addr_q  <= tbl_addr_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            drain_q     <= drain_d;
            acc_en_q    <= acc_en_d;
            acc_new1_q  <= acc_new1_d;
            acc_sel_q   <= acc_sel_d;
            mel_data_q  <= mel_data_d;
            mel_idx_q   <= mel_idx_d;
            mel_valid_q <= mel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tbl_addr      = tbl_addr_q;
    assign acc_en        = acc_en_q;
    assign acc_new1      = acc_new1_q;
    assign acc_sel       = acc_sel_q;
    assign mel.mel_data  = mel_data_q;
    assign mel.mel_idx   = mel_idx_q;
    assign mel.mel_valid = mel_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mel_band_seq.sv
// Directed bench for mel_band_seq with a two-band frame, a registered
// filter table, spectrum/coefficient memories and an accumulator model.
module tb_mel_band_seq;
    import mel_pkg::*;

    localparam int NB = 2;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            cfg_sel;
    logic [IDXW-1:0] tbl_addr;
    logic [BW-1:0]   tbl_lo;
    logic [BW-1:0]   tbl_hi;
    logic [BW-1:0]   bin_addr;
    logic            acc_en;
    logic            acc_new1;
    logic            acc_sel;
    logic [ACCW-1:0] acc_out;
    logic            busy;
    logic            done;

    mel_band_seq_if mel_if();

    mel_band_seq #(.NBANDS(NB), .BINW(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_sel  (cfg_sel),
        .tbl_addr (tbl_addr),
        .tbl_lo   (tbl_lo),
        .tbl_hi   (tbl_hi),
        .bin_addr (bin_addr),
        .acc_en   (acc_en),
        .acc_new1 (acc_new1),
        .acc_sel  (acc_sel),
        .acc_out  (acc_out),
        .mel      (mel_if),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Filter table, memories and accumulator model
    logic [BW-1:0]   lo_tab [2];
    logic [BW-1:0]   hi_tab [2];
    logic [ACCW-1:0] spec_mem [256];
    logic [ACCW-1:0] coef_mem [256];
    logic [ACCW-1:0] acc_reg = '0;
    logic [ACCW-1:0] data_q = '0;
    logic [BW-1:0]   addr_q = '0;

    assign acc_out = acc_reg;

    always @(posedge clk) begin
        tbl_lo <= lo_tab[tbl_addr[0]];
        tbl_hi <= hi_tab[tbl_addr[0]];
        addr_q <= bin_addr;
        data_q <= acc_sel ? coef_mem[bin_addr] : spec_mem[bin_addr];
        if (acc_en) acc_reg <= (acc_new1 ? '0 : acc_reg) + data_q;
    end

    // Cumulative activity counters; tests compare against snapshots
    int          en_cnt = 0, new1_cnt = 0, low_cnt = 0, done_cnt = 0, sel_bad = 0;
    logic [BW-1:0] first_bin = '0, last_bin = '0;
    logic        sel_exp = 1'b0;

    always @(posedge clk) begin
        if (acc_en) begin
            en_cnt++;
            last_bin = addr_q;
            if (addr_q < 8'd250) low_cnt++;
            if (acc_new1) begin
                new1_cnt++;
                first_bin = addr_q;
            end
        end
        if (done) done_cnt++;
        if (busy && (acc_sel != sel_exp)) sel_bad++;
    end

    int total = 0;
    int bad = 0;
    int en_base, new1_base, low_base, done_base, sel_base;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snapStats();
        en_base   = en_cnt;
        new1_base = new1_cnt;
        low_base  = low_cnt;
        done_base = done_cnt;
        sel_base  = sel_bad;
    endtask

    task automatic doStart(input logic sel);
        @(negedge clk);
        cfg_sel = sel;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] lo0, input logic [7:0] hi0,
                                 input logic [7:0] lo1, input logic [7:0] hi1,
                                 input logic sel);
        lo_tab[0] = lo0;
        hi_tab[0] = hi0;
        lo_tab[1] = lo1;
        hi_tab[1] = hi1;
        sel_exp   = sel;
        snapStats();
        doStart(sel);
    endtask

    task automatic waitValid(input string tag, output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mel_if.mel_valid) break;
            cyc++;
        end
        checkOutput({tag, "_valid"}, 64'(mel_if.mel_valid), 64'd1);
    endtask

    task automatic handshake();
        mel_if.mel_ready = 1'b1;
        @(posedge clk);
        #1 mel_if.mel_ready = 1'b0;
    endtask

    task automatic expectBand(input string tag, input int exp_data, input int exp_idx, input int exp_lat);
        int cyc;
        waitValid(tag, cyc);
        checkOutput({tag, "_data"}, 64'(mel_if.mel_data), 64'(exp_data));
        checkOutput({tag, "_idx"}, 64'(mel_if.mel_idx), 64'(exp_idx));
        checkOutput({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        handshake();
    endtask

    task automatic finishFrame(input string tag);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_done"}, 64'(done_cnt - done_base), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_sel"}, 64'(sel_bad - sel_base), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctl"},
                    64'({busy, done, acc_en, acc_new1, acc_sel, mel_if.mel_valid}), 64'd0);
        checkOutput({tag, "_addr"}, 64'({tbl_addr, bin_addr, mel_if.mel_idx}), 64'd0);
        checkOutput({tag, "_data"}, 64'(mel_if.mel_data), 64'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        cfg_sel = 1'b0;
        mel_if.mel_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            spec_mem[i] = '0;
            coef_mem[i] = '0;
        end
        spec_mem[3] = 1;  spec_mem[4] = 2;  spec_mem[5] = 3;  spec_mem[6] = 7;
        spec_mem[9] = 50; spec_mem[10] = 99;
        coef_mem[3] = 10; coef_mem[4] = 20; coef_mem[5] = 30; coef_mem[6] = 100;
        for (int i = 0; i < 6; i++) spec_mem[250 + i] = ACCW'(i + 1);
        lo_tab[0] = 0; hi_tab[0] = 0; lo_tab[1] = 0; hi_tab[1] = 0;

        repeat (3) @(negedge clk);
        checkAllZero("rst");
        reset = 1'b0;

        // Basic frame: bins 3..5 then bin 6
        applyStimulus(8'd3, 8'd5, 8'd6, 8'd6, 1'b0);
        expectBand("a_b0", 6, 0, 7);
        expectBand("a_b1", 7, 1, 5);
        finishFrame("a");
        checkOutput("a_en", 64'(en_cnt - en_base), 64'd4);
        checkOutput("a_new1", 64'(new1_cnt - new1_base), 64'd2);

        // Empty band followed by a normal band
        applyStimulus(8'd10, 8'd9, 8'd6, 8'd6, 1'b0);
        expectBand("b_b0", 0, 0, 2);
        checkOutput("b_en0", 64'(en_cnt - en_base), 64'd0);
        expectBand("b_b1", 7, 1, 5);
        finishFrame("b");

        // Downstream stall of five cycles on band 0
        applyStimulus(8'd3, 8'd5, 8'd6, 8'd6, 1'b0);
        waitValid("c_b0", cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("c_hold_data", 64'(mel_if.mel_data), 64'd6);
            checkOutput("c_hold_idx", 64'(mel_if.mel_idx), 64'd0);
            checkOutput("c_hold_valid", 64'(mel_if.mel_valid), 64'd1);
            checkOutput("c_hold_acc", 64'({acc_en, bin_addr}), 64'd0);
        end
        handshake();
        expectBand("c_b1", 7, 1, 5);
        finishFrame("c");

        // Coefficient path with an ignored mid-frame start
        applyStimulus(8'd3, 8'd5, 8'd6, 8'd6, 1'b1);
        expectBand("d_b0", 60, 0, 7);
        doStart(1'b0);
        expectBand("d_b1", 100, 1, 4);
        finishFrame("d");

        // Top-of-range band must not wrap the bin counter
        applyStimulus(8'd3, 8'd5, 8'd250, 8'd255, 1'b0);
        expectBand("e_b0", 6, 0, 7);
        snapStats();
        expectBand("e_b1", 21, 1, 10);
        checkOutput("e_en", 64'(en_cnt - en_base), 64'd6);
        checkOutput("e_new1", 64'(new1_cnt - new1_base), 64'd1);
        checkOutput("e_wrap", 64'(low_cnt - low_base), 64'd0);
        checkOutput("e_first", 64'(first_bin), 64'd250);
        checkOutput("e_last", 64'(last_bin), 64'd255);
        finishFrame("e");

        // Reset in the middle of band 1 accumulation, then a fresh frame
        applyStimulus(8'd3, 8'd5, 8'd250, 8'd255, 1'b1);
        expectBand("f_b0", 60, 0, 7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("f_rst");
        reset = 1'b0;
        applyStimulus(8'd3, 8'd5, 8'd250, 8'd255, 1'b0);
        expectBand("f_b0b", 6, 0, 7);
        expectBand("f_b1b", 21, 1, 10);
        finishFrame("f");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
